// File: rtl/quad_arb_pkg.sv
// Shared definitions for the quad_array_arbiter block.
//   state_t      : controller states (IDLE waits for a request, RESP holds
//                  the response until it is taken).
//   DEF_*        : default requester count, array depth and entry width.
//   byte_merge   : byte-lane write merge (old byte, new byte, strobe).
package quad_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_DEPTH   = 128;
    localparam int DEF_WIDTH   = 128;

    // One byte lane of a masked write: the new byte replaces the old one
    // only when its strobe is set. Kept byte-sized so it works for any WIDTH.
    function automatic logic [7:0] byte_merge(input logic [7:0] old_byte,
                                              input logic [7:0] new_byte,
                                              input logic       strobe);
        return strobe ? new_byte : old_byte;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   valid     : per-requester request vector
//   rr_ptr    : index that has highest priority this cycle
//   grant     : one-hot grant (all zero when nothing is valid)
//   grant_idx : encoded index of the granted requester (0 when no grant)
// The search starts at rr_ptr and walks upward with wrap-around.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] rr_ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic [IW-1:0] idx;
    logic          found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int i = 0; i < N; i++) begin
            idx = IW'((int'(rr_ptr) + i) % N);
            if (!found && valid[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/quad_array_arbiter.sv
// Shares one DEPTH x WIDTH storage array between NUM_REQ requesters.
// Each requester issues a single-beat read or byte-masked write through
// req_valid/req_ready; the winner's access is performed at the accept edge
// and a response tagged with the requester ID is held until rsp_ready.
//   clk, rst_n   : clock, asynchronous active-low reset
//   req_valid    : per-requester request valid
//   req_ready    : per-requester accept (one-hot or zero)
//   req_write    : per-requester 1 = write, 0 = read
//   req_addr     : packed per-requester entry index
//   req_wdata    : packed per-requester write data
//   req_wstrb    : packed per-requester byte enables
//   rsp_valid    : response valid
//   rsp_ready    : response accept
//   rsp_id       : requester that owns the response
//   rsp_write    : response is a write acknowledge
//   rsp_data     : read data (zero for write acknowledges)
//   txn_count    : completed-transaction counter (wraps)
module quad_array_arbiter
    import quad_arb_pkg::*;
#(
    parameter  int NUM_REQ = DEF_NUM_REQ,
    parameter  int DEPTH   = DEF_DEPTH,
    parameter  int WIDTH   = DEF_WIDTH,
    localparam int IDW     = $clog2(NUM_REQ),
    localparam int AW      = $clog2(DEPTH),
    localparam int SW      = WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ-1:0]    req_write,
    input  logic [NUM_REQ*AW-1:0] req_addr,
    input  logic [NUM_REQ*WIDTH-1:0] req_wdata,
    input  logic [NUM_REQ*SW-1:0] req_wstrb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic                  rsp_write,
    output logic [WIDTH-1:0]      rsp_data,
    output logic [31:0]           txn_count
);

    state_t             state_q;
    logic [IDW-1:0]     rr_ptr_q;
    logic [IDW-1:0]     rsp_id_q;
    logic               rsp_write_q;
    logic [WIDTH-1:0]   rsp_data_q;
    logic [31:0]        txn_q;
    logic [WIDTH-1:0]   mem [DEPTH];

    logic               idle;
    logic [NUM_REQ-1:0] grant;
    logic [IDW-1:0]     gidx;
    logic               fire;
    logic               sel_write;
    logic [AW-1:0]      sel_addr;
    logic [WIDTH-1:0]   sel_wdata;
    logic [SW-1:0]      sel_wstrb;
    logic [WIDTH-1:0]   merged;

    assign idle = (state_q == IDLE);

    // Masking valid with idle keeps req_ready all-zero while a response is held.
    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .valid     (req_valid & {NUM_REQ{idle}}),
        .rr_ptr    (rr_ptr_q),
        .grant     (grant),
        .grant_idx (gidx)
    );

    assign req_ready = grant;
    assign fire      = |(req_valid & grant);

    assign sel_write = req_write[gidx];
    assign sel_addr  = req_addr[gidx*AW +: AW];
    assign sel_wdata = req_wdata[gidx*WIDTH +: WIDTH];
    assign sel_wstrb = req_wstrb[gidx*SW +: SW];

    always_comb begin
        merged = '0;
        for (int b = 0; b < SW; b++) begin
            merged[b*8 +: 8] = byte_merge(mem[sel_addr][b*8 +: 8],
                                          sel_wdata[b*8 +: 8], sel_wstrb[b]);
        end
    end

    // Reset clears the whole array so a pending write is discarded with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            rsp_id_q    <= '0;
            rsp_write_q <= 1'b0;
            rsp_data_q  <= '0;
            txn_q       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (fire) begin
                        rsp_id_q    <= gidx;
                        rsp_write_q <= sel_write;
                        rr_ptr_q    <= (int'(gidx) == NUM_REQ - 1) ? '0 : gidx + 1'b1;
                        state_q     <= RESP;
                        if (sel_write) begin
                            mem[sel_addr] <= merged;
                            rsp_data_q    <= '0;
                        end else begin
                            rsp_data_q    <= mem[sel_addr];
                        end
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        txn_q   <= txn_q + 32'd1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign rsp_id    = rsp_id_q;
    assign rsp_write = rsp_write_q;
    assign rsp_data  = rsp_data_q;
    assign txn_count = txn_q;

endmodule

// File: tb/tb_quad_array_arbiter.sv
module tb_quad_array_arbiter;

    localparam int N  = 4;
    localparam int AW = 7;
    localparam int W  = 128;
    localparam int SW = 16;

    logic              clk;
    logic              rst_n;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      req_write;
    logic [N*AW-1:0]   req_addr;
    logic [N*W-1:0]    req_wdata;
    logic [N*SW-1:0]   req_wstrb;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_id;
    logic              rsp_write;
    logic [W-1:0]      rsp_data;
    logic [31:0]       txn_count;

    int errors = 0;
    int checks = 0;

    localparam logic [W-1:0] D_FULL = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [W-1:0] D_PART = 128'h0123456789ABCDEF0123456789ABCDAA;

    quad_array_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_write (rsp_write),
        .rsp_data  (rsp_data),
        .txn_count (txn_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Presents one request from requester id and returns in the RESP cycle
    // (at a falling edge) with ok=1, or ok=0 if it was never granted.
    task automatic issue(input int id, input logic wr, input logic [AW-1:0] addr,
                         input logic [W-1:0] data, input logic [SW-1:0] strb,
                         output bit ok);
        ok = 1'b0;
        @(negedge clk);
        req_write[id]             = wr;
        req_addr[id*AW +: AW]     = addr;
        req_wdata[id*W +: W]      = data;
        req_wstrb[id*SW +: SW]    = strb;
        req_valid[id]             = 1'b1;
        for (int k = 0; k < 20 && !ok; k++) begin
            #1;
            if (req_ready[id]) begin
                ok = 1'b1;
                @(posedge clk);
            end else begin
                @(negedge clk);
            end
        end
        @(negedge clk);
        req_valid[id] = 1'b0;
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (req_ready !== 4'b0 || rsp_valid !== 1'b0 || rsp_id !== 2'd0 ||
            rsp_write !== 1'b0 || rsp_data !== '0 || txn_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b vld=%b id=%0d wr=%b data=%h cnt=%0d, all zero required",
                     req_ready, rsp_valid, rsp_id, rsp_write, rsp_data, txn_count);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: ready=%b vld=%b, 0 required", req_ready, rsp_valid);
        end
    endtask

    task automatic test_write_read();
        bit ok;
        issue(0, 1'b1, 7'd5, D_FULL, 16'hFFFF, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL wr_grant: not granted, grant required"); end
        checks++;
        if (rsp_valid !== 1'b1 || rsp_write !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== '0) begin
            errors++;
            $display("FAIL wr_ack: vld=%b wr=%b id=%0d data=%h, need 1 1 0 0",
                     rsp_valid, rsp_write, rsp_id, rsp_data);
        end
        finish_rsp();
        issue(0, 1'b0, 7'd5, '0, '0, ok);
        checks++;
        if (!ok || rsp_data !== D_FULL || rsp_write !== 1'b0) begin
            errors++;
            $display("FAIL rd_back: ok=%b data=%h wr=%b, need data %h wr 0",
                     ok, rsp_data, rsp_write, D_FULL);
        end
        finish_rsp();
        checks++;
        if (txn_count !== 32'd2) begin
            errors++;
            $display("FAIL txn_two: got %0d, need 2", txn_count);
        end
    endtask

    task automatic test_partial_write();
        bit ok;
        issue(0, 1'b1, 7'd5, {W{1'b1}} ^ 128'h55, 16'h0001, ok);
        finish_rsp();
        issue(2, 1'b0, 7'd5, '0, '0, ok);
        checks++;
        if (!ok || rsp_data !== D_PART || rsp_id !== 2'd2) begin
            errors++;
            $display("FAIL partial_write: ok=%b id=%0d data=%h, need id 2 data %h",
                     ok, rsp_id, rsp_data, D_PART);
        end
        finish_rsp();
    endtask

    task automatic test_stall();
        bit ok;
        issue(1, 1'b0, 7'd5, '0, '0, ok);
        req_write[2]        = 1'b0;
        req_addr[2*AW +: AW] = 7'd0;
        req_valid[2]        = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_write !== 1'b0 ||
                rsp_data !== D_PART || req_ready !== 4'b0) begin
                errors++;
                $display("FAIL stall_hold c=%0d: vld=%b id=%0d wr=%b data=%h ready=%b, need 1 1 0 %h 0000",
                         c, rsp_valid, rsp_id, rsp_write, rsp_data, req_ready, D_PART);
            end
            @(negedge clk);
        end
        finish_rsp();
        #1;
        checks++;
        if (txn_count !== 32'd5 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_release: cnt=%0d vld=%b, need 5 0", txn_count, rsp_valid);
        end
        // Pointer sits at 2 after granting requester 1.
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL idle_regrant: ready=%b, need 0100", req_ready);
        end
        req_valid[2] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        logic [3:0] e;
        apply_reset();
        for (int i = 0; i < N; i++) begin
            req_write[i]         = 1'b0;
            req_addr[i*AW +: AW] = AW'(i);
        end
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        for (int n = 0; n < 8; n++) begin
            e = 4'(1 << (n % 4));
            #1;
            checks++;
            if (req_ready !== e) begin
                errors++;
                $display("FAIL rr_grant n=%0d: ready=%b, need %b", n, req_ready, e);
            end
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'(n % 4) || req_ready !== 4'b0) begin
                errors++;
                $display("FAIL rr_rsp n=%0d: vld=%b id=%0d ready=%b, need 1 %0d 0000",
                         n, rsp_valid, rsp_id, req_ready, n % 4);
            end
            if (n == 7) req_valid = 4'b0;
            @(negedge clk);
        end
        rsp_ready = 1'b0;
        checks++;
        if (txn_count !== 32'd8) begin
            errors++;
            $display("FAIL rr_count: got %0d, need 8", txn_count);
        end
        repeat (3) @(negedge clk);
        req_valid = 4'b0011;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL rr_ptr_idle: ready=%b, need 0001", req_ready);
        end
        req_valid = 4'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_resp();
        bit ok;
        issue(3, 1'b1, 7'd127, D_FULL, 16'hFFFF, ok);
        checks++;
        if (!ok || rsp_valid !== 1'b1 || rsp_id !== 2'd3) begin
            errors++;
            $display("FAIL mid_setup: ok=%b vld=%b id=%0d, need 1 1 3", ok, rsp_valid, rsp_id);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_write !== 1'b0 || txn_count !== 32'd0) begin
            errors++;
            $display("FAIL async_reset: vld=%b id=%0d wr=%b cnt=%0d, need all 0",
                     rsp_valid, rsp_id, rsp_write, txn_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        issue(0, 1'b0, 7'd127, '0, '0, ok);
        checks++;
        if (!ok || rsp_data !== '0) begin
            errors++;
            $display("FAIL cleared_array: ok=%b data=%h, need 0", ok, rsp_data);
        end
        finish_rsp();
        checks++;
        if (txn_count !== 32'd1) begin
            errors++;
            $display("FAIL count_after_reset: got %0d, need 1", txn_count);
        end
    endtask

    task automatic test_count_wrap();
        bit ok;
        @(negedge clk);
        force dut.txn_q = 32'hFFFF_FFFF;
        #1;
        release dut.txn_q;
        #1;
        checks++;
        if (txn_count !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL wrap_preload: got %h, need ffffffff", txn_count);
        end
        issue(1, 1'b0, 7'd0, '0, '0, ok);
        finish_rsp();
        checks++;
        if (!ok || txn_count !== 32'd0) begin
            errors++;
            $display("FAIL wrap: ok=%b cnt=%h, need 0", ok, txn_count);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_wstrb = '0;
        rsp_ready = 1'b0;
        test_reset();
        test_write_read();
        test_partial_write();
        test_stall();
        test_round_robin();
        test_reset_mid_resp();
        test_count_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
